// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the I/D memory port arbiter.
//   - arb_state_e: arbiter FSM encodings (IDLE=00, GNT_I=01, GNT_D=10)
//   - ARB_STARVE_MAX_DEFAULT: default limit on consecutive D grants while I waits
//   Configuration macro consumed by the arbiter: ARB_STARVE_GUARD_EN
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_e;

  localparam int ARB_STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the requester-side handshakes and the unified memory bus.
//   Ports (all logic):
//     i_req, i_addr[AW]                      fetch request and address
//     d_req, d_we, d_addr[AW], d_wdata[DW]   data request, store flag, address, store data
//     mem_req, mem_we, mem_addr[AW], mem_wdata[DW]   request side of the memory
//     mem_rdata[DW], mem_ready               response side of the memory
//     rdata[DW], i_ready, d_ready, sel       results returned to the requesters
//   Modports:
//     slave  - the arbiter
//     master - requesters plus memory (the environment around the arbiter)
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [DW-1:0] rdata;
  logic          i_ready;
  logic          d_ready;
  logic          sel;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, rdata, i_ready, d_ready, sel
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, rdata, i_ready, d_ready, sel
  );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// mem_port_arbiter_mux2
//   Generic 2-input parameterized mux cell.
//   Ports:
//     choose     in   1      0 selects in0, 1 selects in1
//     in0, in1   in   WIDTH  data inputs
//     out        out  WIDTH  selected data
module mem_port_arbiter_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             choose,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = choose ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (I) and data
//   access (D). One transaction at a time, registered grant (one cycle of
//   arbitration latency), one idle bubble after every completion.
//   Ports:
//     clk   in  1   clock, rising edge
//     rst   in  1   synchronous active-high reset
//     bus   mem_port_arbiter_if.slave  requester handshakes + memory bus
//   Configuration:
//     ARB_STARVE_GUARD_EN  defined: after STARVE_MAX consecutive D completions
//                          while I waits, the next grant goes to I.
//                          undefined: strict D priority, no counter.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic          granted;
  logic          sel;
  logic          starve_hit;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  // A zero limit would make the guard meaningless; reject it at elaboration.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  // State register; a reset abandons any in-flight access without retry.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == STARVE_LIM) && bus.i_req;

  // Counts D completions that happened while I was waiting; saturates at the
  // limit and is wiped the moment I actually gets the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE && state_nxt == ARB_GNT_I) begin
      starve_cnt <= '0;
    end else if (state == ARB_GNT_D && bus.mem_ready && bus.i_req &&
                 starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Next-state and per-state outputs. Completion always returns to IDLE so
  // there is a bubble cycle between transactions.
  always_comb begin
    state_nxt   = state;
    granted     = 1'b0;
    sel         = 1'b0;
    bus.mem_we  = 1'b0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (starve_hit)     state_nxt = ARB_GNT_I;
        else if (bus.d_req) state_nxt = ARB_GNT_D;
        else if (bus.i_req) state_nxt = ARB_GNT_I;
      end
      ARB_GNT_I: begin
        granted     = 1'b1;
        bus.i_ready = bus.mem_ready;
        if (bus.mem_ready) state_nxt = ARB_IDLE;
      end
      ARB_GNT_D: begin
        granted     = 1'b1;
        sel         = 1'b1;
        bus.mem_we  = bus.d_we;
        bus.d_ready = bus.mem_ready;
        if (bus.mem_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // I has no store data, so the wdata mux sees zero on its I leg.
  mem_port_arbiter_mux2 #(.WIDTH(AW)) u_addr_mux (
    .choose (sel),
    .in0    (bus.i_addr),
    .in1    (bus.d_addr),
    .out    (addr_mux)
  );

  mem_port_arbiter_mux2 #(.WIDTH(DW)) u_wdata_mux (
    .choose (sel),
    .in0    ({DW{1'b0}}),
    .in1    (bus.d_wdata),
    .out    (wdata_mux)
  );

  assign bus.mem_req   = granted;
  assign bus.sel       = sel;
  assign bus.mem_addr  = granted ? addr_mux : '0;
  assign bus.mem_wdata = wdata_mux;
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. The bench plays both requesters and
//   the memory. Expected values are hand-derived per cycle.
//   Honors ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ntx;
  logic exp_d;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive every requester and memory input, then let combinational paths settle.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic mready, input logic [31:0] mrdata);
    bus.i_req     = ireq;
    bus.i_addr    = iaddr;
    bus.d_req     = dreq;
    bus.d_we      = dwe;
    bus.d_addr    = daddr;
    bus.d_wdata   = dwdata;
    bus.mem_ready = mready;
    bus.mem_rdata = mrdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset state
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_sel",     bus.sel,     0);
    checkOutput("rst_mem_we",  bus.mem_we,  0);
    checkOutput("rst_i_ready", bus.i_ready, 0);
    checkOutput("rst_d_ready", bus.d_ready, 0);
    rst = 1'b0;

    // Fetch only, memory answers two cycles after the grant
    $display("[TB] fetch-only transaction");
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_latency", bus.mem_req, 0);
    nextCycle();
    checkOutput("t1_mem_req",  bus.mem_req,  1);
    checkOutput("t1_mem_addr", bus.mem_addr, 32'h100);
    checkOutput("t1_sel",      bus.sel,      0);
    checkOutput("t1_mem_we",   bus.mem_we,   0);
    checkOutput("t1_i_early",  bus.i_ready,  0);
    nextCycle();
    checkOutput("t1_hold",     bus.mem_req,  1);
    checkOutput("t1_i_wait",   bus.i_ready,  0);
    nextCycle();
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    checkOutput("t1_i_ready",  bus.i_ready,  1);
    checkOutput("t1_rdata",    bus.rdata,    32'hDEADBEEF);
    checkOutput("t1_d_ready",  bus.d_ready,  0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1);
    checkOutput("t1_idle",      bus.mem_req,  0);
    checkOutput("idle_i_ready", bus.i_ready,  0);
    checkOutput("idle_d_ready", bus.d_ready,  0);
    checkOutput("idle_addr",    bus.mem_addr, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_no_grant", bus.mem_req, 0);
    nextCycle();

    // Simultaneous requests: D first, bubble, then I
    $display("[TB] simultaneous I and D requests");
    applyStimulus(1, 32'h300, 1, 1, 32'h200, 32'h55, 0, 0);
    checkOutput("t2_latency", bus.mem_req, 0);
    nextCycle();
    checkOutput("t2_d_sel",   bus.sel,       1);
    checkOutput("t2_d_req",   bus.mem_req,   1);
    checkOutput("t2_d_we",    bus.mem_we,    1);
    checkOutput("t2_d_addr",  bus.mem_addr,  32'h200);
    checkOutput("t2_d_wdata", bus.mem_wdata, 32'h55);
    applyStimulus(1, 32'h300, 1, 1, 32'h200, 32'h55, 1, 0);
    checkOutput("t2_d_ready", bus.d_ready, 1);
    checkOutput("t2_i_quiet", bus.i_ready, 0);
    nextCycle();
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_bubble",   bus.mem_req, 0);
    checkOutput("t2_bubble_d", bus.d_ready, 0);
    nextCycle();
    checkOutput("t2_i_req",   bus.mem_req,   1);
    checkOutput("t2_i_sel",   bus.sel,       0);
    checkOutput("t2_i_addr",  bus.mem_addr,  32'h300);
    checkOutput("t2_i_we",    bus.mem_we,    0);
    checkOutput("t2_i_wdata", bus.mem_wdata, 0);
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, 32'hCAFE0001);
    checkOutput("t2_i_ready", bus.i_ready, 1);
    checkOutput("t2_rdata",   bus.rdata,   32'hCAFE0001);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_end", bus.mem_req, 0);
    nextCycle();

    // Reset while D holds the port and memory has not answered
    $display("[TB] reset during data grant");
    applyStimulus(0, 0, 1, 0, 32'h40, 0, 0, 0);
    nextCycle();
    checkOutput("t4_granted", bus.mem_req, 1);
    checkOutput("t4_sel_d",   bus.sel,     1);
    rst = 1'b1;
    #1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_mem_req", bus.mem_req, 0);
    checkOutput("t4_sel",     bus.sel,     0);
    checkOutput("t4_d_ready", bus.d_ready, 0);
    nextCycle();
    checkOutput("t4_no_retry", bus.mem_req, 0);

    // Memory always ready, fetch held: ready every second cycle
    $display("[TB] back-to-back fetches with mem_ready tied high");
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 1, 32'h77);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t5_i_ready_%0d", k), bus.i_ready, (k % 2) == 1);
      checkOutput($sformatf("t5_d_ready_%0d", k), bus.d_ready, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_end", bus.i_ready, 0);
    nextCycle();

    // D drops its request right after the grant; transaction still completes
    $display("[TB] data request dropped mid-grant");
    applyStimulus(0, 0, 1, 1, 32'h80, 32'h1234, 0, 0);
    nextCycle();
    checkOutput("t6_grant", bus.mem_req, 1);
    checkOutput("t6_we",    bus.mem_we,  1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h80, 32'h1234, 0, 0);
    checkOutput("t6_hold1",  bus.mem_req, 1);
    checkOutput("t6_quiet1", bus.d_ready, 0);
    nextCycle();
    checkOutput("t6_hold2",  bus.mem_req, 1);
    nextCycle();
    checkOutput("t6_hold3",  bus.mem_req, 1);
    checkOutput("t6_quiet3", bus.d_ready, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h80, 32'h1234, 1, 32'h99);
    checkOutput("t6_d_ready", bus.d_ready, 1);
    checkOutput("t6_hold4",   bus.mem_req, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_idle",    bus.mem_req, 0);
    checkOutput("t6_single",  bus.d_ready, 0);
    nextCycle();
    checkOutput("t6_stay_idle", bus.mem_req, 0);

    // Both requests held, memory always ready: grant order
    $display("[TB] sustained contention");
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    ntx = 8;
`else
    ntx = 20;
`endif
    applyStimulus(1, 32'h600, 1, 0, 32'h700, 0, 1, 0);
    for (int t = 0; t < ntx; t++) begin
      nextCycle();
`ifdef ARB_STARVE_GUARD_EN
      exp_d = (t % 4) != 3;
`else
      exp_d = 1'b1;
`endif
      checkOutput($sformatf("t3_sel_%0d", t),     bus.sel,     exp_d);
      checkOutput($sformatf("t3_req_%0d", t),     bus.mem_req, 1);
      checkOutput($sformatf("t3_d_ready_%0d", t), bus.d_ready, exp_d);
      checkOutput($sformatf("t3_i_ready_%0d", t), bus.i_ready, !exp_d);
      nextCycle();
      checkOutput($sformatf("t3_bubble_%0d", t),  bus.mem_req, 0);
      checkOutput($sformatf("t3_bub_i_%0d", t),   bus.i_ready, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
